// File: rtl/fmint_ram_arbiter.sv
// Single-port access controller for the feature-map tile RAM.
// A producer (writes) and a consumer (reads) share the RAM under round-robin
// arbitration. Between tiles the block can run a zero-fill sweep of the whole
// RAM. Accesses at addr >= N_ELEM are granted but suppressed, and they raise a
// sticky error flag.
//
// state | meaning
// SERVE | arbitrate producer/consumer requests (reset state)
// CLEAR | zero-fill sweep, one address per cycle, requests stalled
module fmint_ram_arbiter #(
  parameter  int N_ELEM = 16,
  parameter  int PX_W_P = 8,
  localparam int AW     = $clog2(N_ELEM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  input  logic [PX_W_P-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [PX_W_P-1:0] rd_data,
  output logic              err,
  output logic [AW-1:0]     ram_addr,
  output logic [PX_W_P-1:0] ram_data,
  output logic              ram_write,
  input  logic [PX_W_P-1:0] ram_res
);

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t              state, state_d;
  logic                prio, prio_d;
  logic [AW-1:0]       cnt, cnt_d;
  logic [AW-1:0]       addr_q;
  logic [PX_W_P-1:0]   data_q;
  logic [PX_W_P-1:0]   rd_hold;
  logic                rd_valid_q;
  logic                rd_oob;
  logic                err_clr;
  logic                wr_in_range;
  logic                rd_in_range;

  assign wr_in_range = (wr_addr < AW'(N_ELEM));
  assign rd_in_range = (rd_addr < AW'(N_ELEM));

  // A read scheduled just before reset is dropped, so rst masks the data path.
  assign rd_valid = rd_valid_q & ~rst;
  assign rd_data  = rst ? '0 : (rd_valid_q ? (rd_oob ? '0 : ram_res) : rd_hold);

  // Next-state, grant and RAM port decode; RAM port holds its last value when idle.
  always_comb begin
    state_d   = state;
    prio_d    = prio;
    cnt_d     = cnt;
    err_clr   = 1'b0;
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    clr_busy  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = addr_q;
    ram_data  = data_q;
    case (state)
      SERVE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          err_clr = 1'b1;
        end else if (wr_req && (!rd_req || !prio)) begin
          wr_gnt    = 1'b1;
          prio_d    = 1'b1;
          ram_addr  = wr_addr;
          ram_data  = wr_data;
          ram_write = wr_in_range;
        end else if (rd_req) begin
          rd_gnt   = 1'b1;
          prio_d   = 1'b0;
          ram_addr = rd_addr;
        end
      end
      CLEAR: begin
        clr_busy  = 1'b1;
        ram_addr  = cnt;
        ram_data  = '0;
        ram_write = 1'b1;
        cnt_d     = cnt + AW'(1);
        if (cnt == AW'(N_ELEM - 1)) state_d = SERVE;
      end
      default: state_d = SERVE;
    endcase
    if (rst) begin
      wr_gnt    = 1'b0;
      rd_gnt    = 1'b0;
      clr_busy  = 1'b0;
      ram_write = 1'b0;
      ram_addr  = '0;
      ram_data  = '0;
    end
  end

  // State, arbitration pointer, sweep counter, read pipeline and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SERVE;
      prio       <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_oob     <= 1'b0;
      rd_hold    <= '0;
      err        <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      state      <= state_d;
      prio       <= prio_d;
      cnt        <= cnt_d;
      addr_q     <= ram_addr;
      data_q     <= ram_data;
      rd_valid_q <= rd_gnt;
      rd_oob     <= rd_gnt & ~rd_in_range;
      if (rd_valid) rd_hold <= rd_data;
      if (err_clr) err <= 1'b0;
      else if ((wr_gnt && !wr_in_range) || (rd_gnt && !rd_in_range)) err <= 1'b1;
      clr_done   <= (state == CLEAR) && (state_d == SERVE);
    end
  end

endmodule

// File: tb/tb_fmint_ram_arbiter.sv
// Scoreboard bench for fmint_ram_arbiter (N_ELEM=16, 8-bit pixels).
// Stimulus pushes the events it expects; a negedge monitor pops and compares
// every visible event (grant, read return, clear step, clear done).
module tb_fmint_ram_arbiter;
  localparam int N  = 16;
  localparam int AW = 5;
  localparam int DW = 8;

  localparam logic [2:0] E_W = 3'd1, E_R = 3'd2, E_RV = 3'd3, E_CLR = 3'd4, E_DONE = 3'd5;

  typedef struct packed {
    logic [2:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
  } ev_t;

  logic clk = 0, rst = 1;
  logic clr_start = 0, clr_busy, clr_done;
  logic wr_req = 0, wr_gnt;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic rd_req = 0, rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic ram_write;
  logic [DW-1:0] ram_res;

  logic [DW-1:0] mem [0:31];
  ev_t sb[$];
  int n_checks = 0, n_fail = 0, cyc = 0;

  fmint_ram_arbiter #(.N_ELEM(N), .PX_W_P(DW)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .err(err), .ram_addr(ram_addr), .ram_data(ram_data), .ram_write(ram_write), .ram_res(ram_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // tile RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_data;
    ram_res <= mem[ram_addr];
  end

  function automatic void push(logic [2:0] k, int a, int d, logic w);
    ev_t e;
    e.kind = k; e.addr = AW'(a); e.data = DW'(d); e.wr = w;
    sb.push_back(e);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic sb_pop(logic [2:0] k, logic [AW-1:0] a, logic [DW-1:0] d, logic w);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event @%0d: got kind=%0d addr=%0d data=%h wr=%b, expected none",
               cyc, k, a, d, w);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr != a || e.data != d || e.wr != w) begin
        n_fail++;
        $display("FAIL event @%0d: got kind=%0d addr=%0d data=%h wr=%b, expected kind=%0d addr=%0d data=%h wr=%b",
                 cyc, k, a, d, w, e.kind, e.addr, e.data, e.wr);
      end
    end
  endtask

  // monitor: every visible DUT event must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_gnt && rd_gnt) chk("single_grant", 2, 1);
      if (rd_valid) sb_pop(E_RV, '0, rd_data, 1'b0);
      if (clr_done) sb_pop(E_DONE, '0, '0, 1'b0);
      if (clr_busy)      sb_pop(E_CLR, ram_addr, ram_data, ram_write);
      else if (wr_gnt)   sb_pop(E_W, ram_addr, ram_data, ram_write);
      else if (rd_gnt)   sb_pop(E_R, ram_addr, '0, ram_write);
      else if (ram_write) sb_pop(3'd0, ram_addr, ram_data, ram_write);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_clear(int steps);
    for (int i = 0; i < steps; i++) push(E_CLR, i, 0, 1'b1);
    clr_start = 1;
  endtask

  int start_cyc, gnt_cyc;
  bit got;

  initial begin
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_wr_gnt", wr_gnt, 0);   chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err, 0);         chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0); chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0); chk("rst_ram_data", ram_data, 0);
    tick();

    // single write then read back
    push(E_W, 3, 'hA5, 1'b1);
    wr_req = 1; wr_addr = 3; wr_data = 8'hA5; tick(); wr_req = 0;
    push(E_R, 3, 0, 1'b0); push(E_RV, 0, 'hA5, 1'b0);
    rd_req = 1; rd_addr = 3; tick(); rd_req = 0;
    tick(); tick();

    // both requesting for 6 cycles: W,R,W,R,W,R
    for (int i = 0; i < 3; i++) begin
      push(E_W, 1, 'h11, 1'b1); push(E_R, 3, 0, 1'b0); push(E_RV, 0, 'hA5, 1'b0);
    end
    wr_req = 1; wr_addr = 1; wr_data = 8'h11; rd_req = 1; rd_addr = 3;
    repeat (6) tick();
    wr_req = 0; rd_req = 0; tick(); tick();

    // preload addr 7, then clear sweep with a write held
    push(E_W, 7, 'h3C, 1'b1);
    wr_req = 1; wr_addr = 7; wr_data = 8'h3C; tick(); wr_req = 0;
    start_clear(N); push(E_DONE, 0, 0, 1'b0); push(E_W, 2, 'h22, 1'b1);
    wr_req = 1; wr_addr = 2; wr_data = 8'h22; start_cyc = cyc;
    tick(); clr_start = 0;
    got = 0; gnt_cyc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (wr_gnt) begin got = 1; gnt_cyc = cyc; end
      tick();
    end
    wr_req = 0;
    chk("clear_wait_gnt_seen", int'(got), 1);
    chk("clear_gnt_latency", gnt_cyc - start_cyc, N + 1);
    chk("clear_err", err, 0);
    push(E_R, 7, 0, 1'b0); push(E_RV, 0, 0, 1'b0);
    rd_req = 1; rd_addr = 7; tick(); rd_req = 0; tick();
    push(E_R, 2, 0, 1'b0); push(E_RV, 0, 'h22, 1'b0);
    rd_req = 1; rd_addr = 2; tick(); rd_req = 0; tick(); tick();

    // out-of-range write and read
    push(E_W, 16, 'h77, 1'b0);
    wr_req = 1; wr_addr = 16; wr_data = 8'h77; tick(); wr_req = 0;
    @(negedge clk); chk("oob_err_set", err, 1);
    tick();
    push(E_R, 20, 0, 1'b0); push(E_RV, 0, 0, 1'b0);
    rd_req = 1; rd_addr = 20; tick(); rd_req = 0;
    repeat (3) tick();
    @(negedge clk); chk("oob_err_sticky", err, 1);
    tick();
    start_clear(N); push(E_DONE, 0, 0, 1'b0);
    tick(); clr_start = 0;
    @(negedge clk); chk("err_cleared", err, 0);
    repeat (18) tick();

    // reset during the read return cycle drops the read
    push(E_R, 3, 0, 1'b0);
    rd_req = 1; rd_addr = 3; tick(); rd_req = 0; rst = 1;
    @(negedge clk); chk("rst_drops_rd_valid", rd_valid, 0);
    tick(); rst = 0; tick();

    // reset at sweep cycle 5
    start_clear(4);
    tick(); clr_start = 0;
    repeat (4) tick();
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("midrst_clr_busy", clr_busy, 0); chk("midrst_ram_write", ram_write, 0);
    chk("midrst_ram_addr", ram_addr, 0); chk("midrst_clr_done", clr_done, 0);
    repeat (20) tick();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/fmint_ram_arbiter.md
# fmint_ram_arbiter

Single-port access controller for the intermediate-result feature-map tile RAM. It shares that RAM between a producer (expansion stage writing intermediate pixels) and a consumer (depthwise stage reading them) using round-robin arbitration. It also sequences a full-tile clear sweep between tiles and flags out-of-range accesses. It sits directly in front of the tile RAM and drives that RAM's address, data and write ports; the RAM has one-cycle registered read latency.

## Interface
- N_ELEM, FMINT_N_ELEM: number of pixels in the tile RAM
- PX_W_P, PX_W: pixel width in bits
- AW (derived, not overridable), $clog2(N_ELEM+1): address width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- clr_start  in  1  pulse: start zero-fill sweep of whole tile
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes
- wr_req  in  1  producer write request
- wr_addr  in  AW  producer address
- wr_data  in  PX_W_P  producer data
- wr_gnt  out  1  write accepted this cycle
- rd_req  in  1  consumer read request
- rd_addr  in  AW  consumer address
- rd_gnt  out  1  read accepted this cycle
- rd_valid  out  1  rd_data valid (one cycle after rd_gnt)
- rd_data  out  PX_W_P  read pixel
- err  out  1  sticky out-of-range flag
- ram_addr  out  AW  to RAM addr
- ram_data  out  PX_W_P  to RAM data
- ram_write  out  1  to RAM write
- ram_res  in  PX_W_P  from RAM res

## Operation
- FSM states: SERVE (reset state) and CLEAR.
- SERVE:
  - Requests are accepted if and only if clr_start=0.
  - Only one requester active: that requester is granted.
  - Both active: the side indicated by the priority bit `prio` is granted (0 = write, 1 = read).
  - After any grant, `prio` points to the non-granted side. The reset value of `prio` is 0.
- Granted write: ram_addr=wr_addr, ram_data=wr_data, ram_write=1.
- Granted read: ram_addr=rd_addr, ram_write=0. On the next cycle, rd_valid=1 and rd_data=ram_res.
- No grant: ram_write=0; ram_addr and ram_data hold their last value (registered mirror).
- Out-of-range access (addr >= N_ELEM):
  - The request is still granted, so the requester is never stalled.
  - A write has ram_write forced to 0.
  - A read returns rd_data=0 with rd_valid=1.
  - err sets on the next cycle.
- clr_start=1 in SERVE:
  - No grant that cycle.
  - Clear counter is set to 0, err is cleared, and the FSM moves to CLEAR.
- CLEAR:
  - Each cycle drives ram_addr=cnt, ram_data=0, ram_write=1, then increments cnt.
  - wr_gnt=rd_gnt=0 and clr_busy=1.
  - clr_start is ignored.
  - On the cycle with cnt=N_ELEM-1, the FSM moves to SERVE and clr_done pulses on the following cycle.
- Requests held during CLEAR are neither lost nor queued by this block. The requester must hold req until it sees gnt.
- Requester rule: req, addr and data must stay stable while req=1 and gnt=0.

## Timing
- Reset values: wr_gnt=0, rd_gnt=0, rd_valid=0, rd_data=0, err=0, clr_busy=0, clr_done=0, ram_write=0, ram_addr=0, ram_data=0, prio=0, state=SERVE.
- Grant outputs and the ram_* outputs are combinational from req inputs, state and `prio`: zero-cycle grant.
- Read latency is 1 cycle from rd_gnt to rd_valid. rd_data holds its value until the next rd_valid.
- Throughput is one access per cycle. With both requesters continuously active, grants strictly alternate (W,R,W,R…).
- A clear sweep takes exactly N_ELEM cycles of clr_busy=1. clr_done occurs N_ELEM+1 cycles after the clr_start cycle.
- rst asserted mid-sweep: next cycle is SERVE with all reset values. The partial clear is not resumed and no clr_done is issued.
- rst asserted the cycle after a read grant: rd_valid=0. The pending read is dropped.
- clr_start and err-set in the same cycle: the clear wins, so err=0.

## Test plan
- Reset, then wr_req alone at addr 3, data 0xA5: wr_gnt=1 same cycle, ram_write=1, ram_addr=3. A later rd_req at addr 3 gives rd_gnt, then rd_valid next cycle with rd_data=0xA5.
- wr_req and rd_req both held for 6 cycles after reset: grants go W,R,W,R,W,R; exactly one gnt per cycle; rd_valid follows each rd_gnt by 1 cycle.
- N_ELEM=16, clr_start with wr_req active: no grant for 16 cycles, ram_addr steps 0..15 with ram_data=0 and ram_write=1. clr_done pulses at cycle 17, then wr_gnt on the first SERVE cycle.
- Write addr 16 (N_ELEM=16): wr_gnt=1, ram_write=0, err=1 next cycle. Read addr 20: rd_valid with rd_data=0. err stays 1 until clr_start.
- rst pulsed at sweep cycle 5: outputs return to reset values, clr_busy=0, and no clr_done is seen for 20 cycles.
- Preload addr 7 = 0x3C, clear sweep, then read addr 7: rd_data=0x00.
